// File: rtl/rubik_pkg.sv
// Shared definitions for the gripper move path: FSM state encoding and the
// layout of the 3-bit move code.
package rubik_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_POP     = 3'd1,
      ST_WAIT    = 3'd2,
      ST_LATCH   = 3'd3,
      ST_STEP_HI = 3'd4,
      ST_STEP_LO = 3'd5,
      ST_SETTLE  = 3'd6
   } state_t;

   localparam int MOTOR_IDX_W = 2;
   localparam int MOTOR_LSB   = 0;
   localparam int DIR_BIT     = 2;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// Fixed-length step pulse train for one selected motor: STEPS_PER_MOVE periods
// of HALF_PERIOD high then HALF_PERIOD low, with a done pulse on the final low cycle.
module step_pulse_gen
   import rubik_pkg::*;
#(
   parameter int N_MOTORS       = 4,
   parameter int STEPS_PER_MOVE = 50,
   parameter int HALF_PERIOD    = 25000,
   parameter int TMR_W          = 15,
   parameter int CNT_W          = 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [MOTOR_IDX_W-1:0] motor,
   output logic [N_MOTORS-1:0]    step,
   output logic                   done
);

   localparam logic [TMR_W-1:0] HP_LOAD    = TMR_W'(HALF_PERIOD - 1);
   localparam logic [CNT_W-1:0] STEPS_LOAD = CNT_W'(STEPS_PER_MOVE);

   state_t                 phase_q, phase_d;
   logic [TMR_W-1:0]       tmr_q, tmr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [MOTOR_IDX_W-1:0] motor_q, motor_d;

   always_comb begin
      phase_d = phase_q;
      tmr_d   = tmr_q;
      cnt_d   = cnt_q;
      motor_d = motor_q;
      done    = 1'b0;
      case (phase_q)
         ST_STEP_HI: begin
            if (tmr_q == '0) begin
               phase_d = ST_STEP_LO;
               tmr_d   = HP_LOAD;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         ST_STEP_LO: begin
            if (tmr_q == '0) begin
               cnt_d = cnt_q - 1'b1;
               tmr_d = HP_LOAD;
               // Count holds the steps still owed including this one.
               if (cnt_q == CNT_W'(1)) begin
                  done    = 1'b1;
                  phase_d = ST_IDLE;
               end else begin
                  phase_d = ST_STEP_HI;
               end
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: begin
            if (start) begin
               phase_d = ST_STEP_HI;
               tmr_d   = HP_LOAD;
               cnt_d   = STEPS_LOAD;
               motor_d = motor;
            end
         end
      endcase
   end

   always_comb begin
      step = '0;
      for (int i = 0; i < N_MOTORS; i++)
         step[i] = (phase_q == ST_STEP_HI) && (motor_q == MOTOR_IDX_W'(i));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= ST_IDLE;
         tmr_q   <= '0;
         cnt_q   <= '0;
         motor_q <= '0;
      end else begin
         phase_q <= phase_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         motor_q <= motor_d;
      end
   end

endmodule

// File: rtl/move_sequencer.sv
// Pops move codes from the move FIFO, drives a step/dir pulse train on the
// addressed motor, then settles before the next pop.
module move_sequencer
   import rubik_pkg::*;
#(
   parameter int DATO_WIDTH     = 3,
   parameter int N_MOTORS       = 4,
   parameter int STEPS_PER_MOVE = 50,
   parameter int HALF_PERIOD    = 25000,
   parameter int SETTLE_CYCLES  = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic [DATO_WIDTH-1:0] fifo_dat,
   output logic                  fifo_rd,
   output logic [N_MOTORS-1:0]   step,
   output logic [N_MOTORS-1:0]   dir,
   output logic                  busy,
   output logic                  move_done,
   output logic [15:0]           moves_cnt
);

   localparam int TMR_W = $clog2(max_i(HALF_PERIOD, SETTLE_CYCLES) + 1);
   localparam int CNT_W = $clog2(STEPS_PER_MOVE + 1);
   localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

   state_t               state_q, state_d;
   logic [TMR_W-1:0]     tmr_q, tmr_d;
   logic [N_MOTORS-1:0]  dir_q, dir_d;
   logic [15:0]          moves_q, moves_d;
   logic                 gen_start, gen_done;
   logic [MOTOR_IDX_W-1:0] code_motor;

   assign code_motor = fifo_dat[MOTOR_LSB +: MOTOR_IDX_W];

   // ST_STEP_HI here covers the whole pulse train; the HI/LO phase lives in the generator.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      dir_d     = dir_q;
      moves_d   = moves_q;
      gen_start = 1'b0;
      case (state_q)
         ST_IDLE:  if (en && !fifo_empty) state_d = ST_POP;
         ST_POP:   state_d = ST_WAIT;
         ST_WAIT:  state_d = ST_LATCH;
         ST_LATCH: begin
            gen_start = 1'b1;
            for (int i = 0; i < N_MOTORS; i++)
               if (code_motor == MOTOR_IDX_W'(i)) dir_d[i] = fifo_dat[DIR_BIT];
            state_d = ST_STEP_HI;
         end
         ST_STEP_HI: begin
            if (gen_done) begin
               state_d = ST_SETTLE;
               tmr_d   = SETTLE_LOAD;
            end
         end
         ST_SETTLE: begin
            if (tmr_q == '0) begin
               moves_d = moves_q + 16'd1;
               state_d = ST_IDLE;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         dir_q   <= '0;
         moves_q <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         dir_q   <= dir_d;
         moves_q <= moves_d;
      end
   end

   step_pulse_gen #(
      .N_MOTORS      (N_MOTORS),
      .STEPS_PER_MOVE(STEPS_PER_MOVE),
      .HALF_PERIOD   (HALF_PERIOD),
      .TMR_W         (TMR_W),
      .CNT_W         (CNT_W)
   ) u_gen (
      .clk  (clk),
      .rst_n(rst_n),
      .start(gen_start),
      .motor(code_motor),
      .step (step),
      .done (gen_done)
   );

   assign fifo_rd   = (state_q == ST_POP);
   assign busy      = (state_q != ST_IDLE);
   assign move_done = (state_q == ST_SETTLE) && (tmr_q == '0);
   assign dir       = dir_q;
   assign moves_cnt = moves_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a small FIFO model and a negedge
// monitor tallying read strobes and step edges.
module tb_move_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        fifo_empty;
   logic [2:0]  fifo_dat = 3'b000;
   logic        fifo_rd;
   logic [3:0]  step;
   logic [3:0]  dir;
   logic        busy;
   logic        move_done;
   logic [15:0] moves_cnt;

   int checks = 0;
   int failures = 0;

   logic [2:0] mem [16];
   int wr_ptr = 0;
   int rd_ptr = 0;

   int cyc = 0;
   int rd_cnt = 0;
   int rd_empty_cnt = 0;
   int last_rd_cyc = 0;
   int prev_rd_cyc = 0;
   int busy_cnt = 0;
   int multi_cnt = 0;
   int rise [4] = '{0, 0, 0, 0};
   logic [3:0] step_prev = 4'b0;

   always #5 clk = ~clk;

   move_sequencer #(
      .DATO_WIDTH(3), .N_MOTORS(4), .STEPS_PER_MOVE(4),
      .HALF_PERIOD(2), .SETTLE_CYCLES(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty),
      .fifo_dat(fifo_dat), .fifo_rd(fifo_rd), .step(step), .dir(dir),
      .busy(busy), .move_done(move_done), .moves_cnt(moves_cnt)
   );

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_rd && !fifo_empty) begin
         fifo_dat <= mem[rd_ptr % 16];
         rd_ptr   <= rd_ptr + 1;
      end
   end

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (fifo_rd) begin
         rd_cnt = rd_cnt + 1;
         prev_rd_cyc = last_rd_cyc;
         last_rd_cyc = cyc;
         if (fifo_empty) rd_empty_cnt = rd_empty_cnt + 1;
      end
      for (int i = 0; i < 4; i++)
         if (step[i] && !step_prev[i]) rise[i] = rise[i] + 1;
      step_prev = step;
      if ($countones(step) > 1) multi_cnt = multi_cnt + 1;
      if (busy) busy_cnt = busy_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] code);
      mem[wr_ptr % 16] = code;
      wr_ptr = wr_ptr + 1;
   endtask

   initial begin
      int n;
      int b_rd, b_r0, b_r1, b_r3, b_busy;
      logic [3:0] exp_step;
      logic [3:0] exp_dir;

      // Reset with a code already queued
      rst_n = 1'b0;
      en    = 1'b1;
      push(3'b110);
      tick(); tick();
      check("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
      check("rst_step", {28'd0, step}, 32'd0);
      check("rst_dir", {28'd0, dir}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_moves", {16'd0, moves_cnt}, 32'd0);
      en = 1'b0;
      rst_n = 1'b1;
      tick(); tick(); tick();
      check("hold_en0_rd", rd_cnt, 0);
      check("hold_en0_busy", {31'd0, busy}, 32'd0);

      // Single move, code 110: motor 2, clockwise, 22 cycles
      en = 1'b1;
      tick();
      for (int t = 0; t < 22; t++) begin
         exp_step = (t >= 3 && t <= 18 && ((t - 3) % 4) < 2) ? 4'b0100 : 4'b0000;
         exp_dir  = (t >= 3) ? 4'b0100 : 4'b0000;
         check($sformatf("single_t%0d", t),
               {21'd0, fifo_rd, step, dir, busy, move_done},
               {21'd0, (t == 0), exp_step, exp_dir, 1'b1, (t == 21)});
         tick();
      end
      check("single_busy_end", {31'd0, busy}, 32'd0);
      check("single_moves", {16'd0, moves_cnt}, 32'd1);
      check("single_rd_cnt", rd_cnt, 1);

      // Back-to-back: 000 then 011
      b_rd = rd_cnt; b_r0 = rise[0]; b_r3 = rise[3];
      push(3'b000);
      push(3'b011);
      n = 0;
      while (moves_cnt != 16'd3 && n < 200) begin tick(); n++; end
      check("b2b_timeout", {31'd0, (n < 200)}, 32'd1);
      tick();
      check("b2b_rd", rd_cnt - b_rd, 2);
      check("b2b_step0", rise[0] - b_r0, 4);
      check("b2b_step3", rise[3] - b_r3, 4);
      check("b2b_dir", {28'd0, dir}, 32'h4);
      check("b2b_gap", last_rd_cyc - prev_rd_cyc, 23);
      check("b2b_moves", {16'd0, moves_cnt}, 32'd3);

      // en dropped during second step of a move; another code waits in the FIFO
      b_rd = rd_cnt; b_r1 = rise[1];
      push(3'b101);
      push(3'b010);
      tick();
      check("endrop_pop", {31'd0, fifo_rd}, 32'd1);
      repeat (7) tick();
      check("endrop_2nd_hi", {28'd0, step}, 32'h2);
      en = 1'b0;
      n = 0;
      while (!move_done && n < 100) begin tick(); n++; end
      check("endrop_timeout", {31'd0, (n < 100)}, 32'd1);
      repeat (20) tick();
      check("endrop_steps", rise[1] - b_r1, 4);
      check("endrop_rd", rd_cnt - b_rd, 1);
      check("endrop_dir", {28'd0, dir}, 32'h6);
      check("endrop_busy", {31'd0, busy}, 32'd0);
      check("endrop_moves", {16'd0, moves_cnt}, 32'd4);
      en = 1'b1;
      tick();
      check("en_resume_rd", {31'd0, fifo_rd}, 32'd1);

      // Reset in the middle of STEP_HI of code 010
      repeat (3) tick();
      check("midrst_pre_step", {28'd0, step}, 32'h4);
      rst_n = 1'b0;
      #1;
      check("midrst_step", {28'd0, step}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_moves", {16'd0, moves_cnt}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check("postrst_busy", {31'd0, busy}, 32'd0);
      check("postrst_moves", {16'd0, moves_cnt}, 32'd0);
      check("postrst_dir", {28'd0, dir}, 32'd0);

      // Empty FIFO with en high
      b_rd = rd_cnt; b_busy = busy_cnt;
      repeat (100) tick();
      check("empty_rd", rd_cnt - b_rd, 0);
      check("empty_busy", busy_cnt - b_busy, 0);

      check("onehot_step", multi_cnt, 0);
      check("rd_while_empty", rd_empty_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
